// File: rtl/uart_bfm_agent_if.sv
// Byte-side handshake and serial pins of the UART agent.
// The agent itself takes the slave view.
interface uart_bfm_agent_if #(
   parameter int TX_DEPTH = 4
);
   localparam int LW = $clog2(TX_DEPTH) + 1;

   logic          tx_valid;
   logic          tx_ready;
   logic [7:0]    tx_data;
   logic [LW-1:0] tx_level;
   logic          tx_busy;
   logic          rxd_o;
   logic          txd_i;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_parity_err;
   logic          rx_frame_err;

   modport slave (
      input  tx_valid, tx_data, txd_i,
      output tx_ready, tx_level, tx_busy, rxd_o,
             rx_valid, rx_data, rx_parity_err, rx_frame_err
   );

   modport master (
      output tx_valid, tx_data, txd_i,
      input  tx_ready, tx_level, tx_busy, rxd_o,
             rx_valid, rx_data, rx_parity_err, rx_frame_err
   );
endinterface

// File: rtl/uart_bfm_agent.sv
// UART agent: FIFO-buffered serialiser driving rxd_o, and a deserialiser
// on txd_i that reports parity and framing errors. Full duplex.
module uart_bfm_agent #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int BAUD      = 115200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1,
   parameter int TX_DEPTH  = 4
) (
   input  logic             c0_sys_clk_p,
   input  logic             reset_btn_n,
   uart_bfm_agent_if.slave  bus
);
   localparam int            DIV      = CLK_HZ / BAUD;
   localparam int            CW       = $clog2(DIV) + 1;
   localparam int            AW       = $clog2(TX_DEPTH);
   localparam int            LW       = AW + 1;
   localparam logic [CW-1:0] CNT_TOP  = CW'(DIV - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
   localparam logic [7:0]    DMASK    = 8'((1 << DATA_BITS) - 1);
   localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic          ODD      = 1'(PARITY == 1);

   // ---------------- TX FIFO ----------------
   logic [7:0]    mem [TX_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic          push, pop;

   assign bus.tx_ready = (level != LW'(TX_DEPTH));
   assign bus.tx_level = level;
   assign push         = bus.tx_valid & bus.tx_ready;

   always_ff @(posedge c0_sys_clk_p or negedge reset_btn_n) begin
      if (!reset_btn_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         level <= level + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge c0_sys_clk_p) begin
      if (push) mem[wr_ptr] <= bus.tx_data & DMASK;
   end

   // ---------------- TX serialiser ----------------
   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PARITY, T_STOP} tx_state_t;
   tx_state_t     tx_state, tx_state_n;
   logic [CW-1:0] tx_cnt;
   logic [2:0]    tx_bit;
   logic          tx_stop;
   logic [7:0]    tx_shift;
   logic          tx_par, tx_line, tx_tick, rxd_q, tx_busy_q;

   assign tx_tick     = (tx_cnt == '0);
   assign bus.rxd_o   = rxd_q;
   assign bus.tx_busy = tx_busy_q;

   always_comb begin
      tx_state_n = tx_state;
      pop        = 1'b0;
      tx_line    = 1'b1;
      unique case (tx_state)
         T_IDLE: if (level != '0) begin
            pop        = 1'b1;
            tx_state_n = T_START;
         end
         T_START: begin
            tx_line = 1'b0;
            if (tx_tick) tx_state_n = T_DATA;
         end
         T_DATA: begin
            tx_line = tx_shift[0];
            if (tx_tick && tx_bit == LAST_BIT) tx_state_n = (PARITY != 0) ? T_PARITY : T_STOP;
         end
         T_PARITY: begin
            tx_line = tx_par;
            if (tx_tick) tx_state_n = T_STOP;
         end
         T_STOP: if (tx_tick && tx_stop == 1'(STOP_BITS - 1)) begin
            // Queued data chains straight into the next start bit.
            if (level != '0) begin
               pop        = 1'b1;
               tx_state_n = T_START;
            end else begin
               tx_state_n = T_IDLE;
            end
         end
         default: tx_state_n = T_IDLE;
      endcase
   end

   always_ff @(posedge c0_sys_clk_p or negedge reset_btn_n) begin
      if (!reset_btn_n) tx_state <= T_IDLE;
      else              tx_state <= tx_state_n;
   end

   // Line and busy are registered so the pin is glitch-free.
   always_ff @(posedge c0_sys_clk_p or negedge reset_btn_n) begin
      if (!reset_btn_n) begin
         tx_cnt    <= CNT_TOP;
         tx_bit    <= '0;
         tx_stop   <= 1'b0;
         tx_shift  <= '0;
         tx_par    <= 1'b0;
         rxd_q     <= 1'b1;
         tx_busy_q <= 1'b0;
      end else begin
         rxd_q     <= tx_line;
         tx_busy_q <= (tx_state != T_IDLE);
         if (pop) begin
            tx_shift <= mem[rd_ptr];
            tx_par   <= ^mem[rd_ptr] ^ ODD;
            tx_cnt   <= CNT_TOP;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
         end else if (tx_state != T_IDLE) begin
            if (tx_tick) begin
               tx_cnt <= CNT_TOP;
               if (tx_state == T_DATA) begin
                  tx_shift <= tx_shift >> 1;
                  tx_bit   <= (tx_bit == LAST_BIT) ? '0 : tx_bit + 1'b1;
               end
               if (tx_state == T_STOP) tx_stop <= ~tx_stop;
            end else begin
               tx_cnt <= tx_cnt - 1'b1;
            end
         end
      end
   end

   // ---------------- RX deserialiser ----------------
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP, R_BREAK} rx_state_t;
   rx_state_t     rx_state, rx_state_n;
   logic          rx_s1, rx_s2, rx_prev;
   logic [CW-1:0] rx_cnt;
   logic [2:0]    rx_bit;
   logic [7:0]    rx_shift, rx_word;
   logic          rx_par_bit, rx_tick, rx_fall, rx_done;
   logic          rx_valid_q, rx_perr_q, rx_ferr_q;
   logic [7:0]    rx_data_q;

   assign rx_tick           = (rx_cnt == '0);
   assign rx_fall           = rx_prev & ~rx_s2;
   assign rx_word           = rx_shift >> (8 - DATA_BITS);
   assign bus.rx_valid      = rx_valid_q;
   assign bus.rx_data       = rx_data_q;
   assign bus.rx_parity_err = rx_perr_q;
   assign bus.rx_frame_err  = rx_ferr_q;

   always_comb begin
      rx_state_n = rx_state;
      rx_done    = 1'b0;
      unique case (rx_state)
         R_IDLE:   if (rx_fall) rx_state_n = R_START;
         R_START:  if (rx_tick) rx_state_n = rx_s2 ? R_IDLE : R_DATA;
         R_DATA:   if (rx_tick && rx_bit == LAST_BIT) rx_state_n = (PARITY != 0) ? R_PARITY : R_STOP;
         R_PARITY: if (rx_tick) rx_state_n = R_STOP;
         R_STOP: if (rx_tick) begin
            rx_done    = 1'b1;
            rx_state_n = rx_s2 ? R_IDLE : R_BREAK;
         end
         // A held-low line must not retrigger a start.
         R_BREAK:  if (rx_s2) rx_state_n = R_IDLE;
         default:  rx_state_n = R_IDLE;
      endcase
   end

   always_ff @(posedge c0_sys_clk_p or negedge reset_btn_n) begin
      if (!reset_btn_n) rx_state <= R_IDLE;
      else              rx_state <= rx_state_n;
   end

   always_ff @(posedge c0_sys_clk_p or negedge reset_btn_n) begin
      if (!reset_btn_n) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_prev    <= 1'b1;
         rx_cnt     <= CNT_HALF;
         rx_bit     <= '0;
         rx_shift   <= '0;
         rx_par_bit <= 1'b0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
      end else begin
         rx_s1      <= bus.txd_i;
         rx_s2      <= rx_s1;
         rx_prev    <= rx_s2;
         rx_valid_q <= rx_done;
         // Half-bit wait from the falling edge puts every later sample mid-bit.
         if (rx_state == R_IDLE) rx_cnt <= CNT_HALF;
         else if (rx_tick)       rx_cnt <= CNT_TOP;
         else                    rx_cnt <= rx_cnt - 1'b1;
         if (rx_state == R_DATA && rx_tick) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bit   <= (rx_bit == LAST_BIT) ? '0 : rx_bit + 1'b1;
         end
         if (rx_state == R_PARITY && rx_tick) rx_par_bit <= rx_s2;
         if (rx_done) begin
            rx_data_q <= rx_word;
            rx_perr_q <= (PARITY != 0) & (^rx_word ^ rx_par_bit ^ ODD);
            rx_ferr_q <= ~rx_s2;
         end
      end
   end
endmodule
